// File: rtl/key_ctrl.sv
// Key front end for the time-setting path: synchronises and debounces the mode/add/sub
// buttons, emits one-cycle release pulses and holds the one-hot adjust-mode register.
module key_ctrl #(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned IDLE_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_add,
  input  logic       key_sub,
  output logic       btn_add,
  output logic       btn_sub,
  output logic [2:0] set
);

  localparam int unsigned DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int unsigned IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN  = 3'b001,
    ST_MIN  = 3'b010,
    ST_HOUR = 3'b100
  } mode_e;

  logic [2:0] raw;
  logic [2:0] rel;
  logic [2:0] edge_k;
  logic       rel_mode, rel_add, rel_sub;
  logic       any_edge;

  assign raw = {key_sub, key_add, key_mode};

  for (genvar g = 0; g < 3; g++) begin : g_key
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             prev_q, prev_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d  = raw[g];
      sync2_d  = sync1_q;
      prev_d   = stable_q;
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
        if (cnt_q == DEB_MAX) begin
          stable_d = sync2_q;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        stable_q <= 1'b1;
        prev_q   <= 1'b1;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        stable_q <= stable_d;
        prev_q   <= prev_d;
        cnt_q    <= cnt_d;
      end
    end

    // Events are taken from the registered stable level, one cycle after it settles.
    assign rel[g]    = stable_q & ~prev_q;
    assign edge_k[g] = stable_q ^ prev_q;
  end

  assign rel_mode = rel[0];
  assign rel_add  = rel[1];
  assign rel_sub  = rel[2];
  assign any_edge = |edge_k;

  mode_e             state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              btn_add_q, btn_add_d;
  logic              btn_sub_q, btn_sub_d;
  logic              timeout;

  always_comb begin
    state_d   = state_q;
    idle_d    = '0;
    btn_add_d = 1'b0;
    btn_sub_d = 1'b0;
    timeout   = (state_q != ST_RUN) && (idle_q == IDLE_MAX);

    if ((state_q != ST_RUN) && !any_edge && !timeout) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    // A mode release outranks a coincident timeout.
    if (rel_mode) begin
      case (state_q)
        ST_RUN:  state_d = ST_MIN;
        ST_MIN:  state_d = ST_HOUR;
        default: state_d = ST_RUN;
      endcase
    end else if (timeout) begin
      state_d = ST_RUN;
    end

    btn_add_d = rel_add & ~rel_sub & ~rel_mode;
    btn_sub_d = rel_sub & ~rel_add & ~rel_mode;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      idle_q    <= '0;
      btn_add_q <= 1'b0;
      btn_sub_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      btn_add_q <= btn_add_d;
      btn_sub_q <= btn_sub_d;
    end
  end

  assign btn_add = btn_add_q;
  assign btn_sub = btn_sub_q;
  assign set     = state_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Bench for key_ctrl: directed scenarios plus random key activity, all outputs compared
// every cycle against a sample-window model of debounce, events and the mode/idle rules.
module tb_key_ctrl;

  localparam int DEB  = 8;
  localparam int IDLE = 100;
  localparam int HL   = DEB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_add = 1'b1;
  logic       key_sub = 1'b1;
  logic       btn_add;
  logic       btn_sub;
  logic [2:0] set;

  key_ctrl #(.DEB_CYCLES(DEB), .IDLE_CYCLES(IDLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_mode(key_mode),
    .key_add (key_add),
    .key_sub (key_sub),
    .btn_add (btn_add),
    .btn_sub (btn_sub),
    .set     (set)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int n_add = 0;
  int n_sub = 0;
  int last_add = -1;

  // Model: h[i][j] is the raw level sampled j+1 edges ago for key i.
  bit         h [3][HL];
  bit         m_stable [3];
  bit         pend_rel [3];
  bit         pend_any;
  int         m_mode;
  bit         m_add, m_sub;
  int         last_ref;
  logic [2:0] exp_set;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < HL; j++) h[i][j] = 1'b1;
      m_stable[i] = 1'b1;
      pend_rel[i] = 1'b0;
    end
    pend_any = 1'b0;
    m_mode   = 0;
    m_add    = 1'b0;
    m_sub    = 1'b0;
    last_ref = cyc;
  endtask

  task automatic model_step();
    bit         timeout;
    bit         diff;
    bit [2:0]   k;
    k = {key_sub, key_add, key_mode};
    timeout = (m_mode != 0) && (cyc - last_ref == IDLE);
    m_add = pend_rel[1] && !pend_rel[2] && !pend_rel[0];
    m_sub = pend_rel[2] && !pend_rel[1] && !pend_rel[0];
    if (pend_any) last_ref = cyc;
    if (pend_rel[0]) m_mode = (m_mode + 1) % 3;
    else if (timeout) m_mode = 0;
    pend_any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      diff = 1'b1;
      for (int j = 1; j <= DEB; j++) if (h[i][j] == m_stable[i]) diff = 1'b0;
      pend_rel[i] = diff && !m_stable[i];
      if (diff) begin
        pend_any    = 1'b1;
        m_stable[i] = !m_stable[i];
      end
      for (int j = HL - 1; j > 0; j--) h[i][j] = h[i][j-1];
      h[i][0] = k[i];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_step();
      #1;
      exp_set = 3'b001 << m_mode;
      chk("btn_add", 32'(btn_add), 32'(m_add));
      chk("btn_sub", 32'(btn_sub), 32'(m_sub));
      chk("set", 32'(set), 32'(exp_set));
      if (btn_add === 1'b1) begin
        n_add++;
        last_add = cyc;
      end
      if (btn_sub === 1'b1) n_sub++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_set(input logic [2:0] v, input int bound, input string name, output int at);
    at = -1;
    for (int k = 0; k < bound && at < 0; k++) begin
      @(posedge clk);
      #1;
      if (set === v) at = cyc;
    end
    if (at < 0) begin
      chk(name, 32'(set), 32'(v));
      at = cyc;
    end
  endtask

  task automatic run_random(input int cycles, input int maxh);
    int       hold [3];
    logic [2:0] kv;
    kv = {key_sub, key_add, key_mode};
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, maxh);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          kv[i]   = ~kv[i];
          hold[i] = $urandom_range(1, maxh);
        end
      end
      {key_sub, key_add, key_mode} = kv;
      rst_n = ($urandom_range(0, 999) != 0);
    end
  endtask

  initial begin
    int         a0, s0, rel_edge, t0, t1;
    logic [2:0] steps [3];
    steps = '{3'b010, 3'b100, 3'b001};

    rst_n = 1'b0;
    nclk(3);
    rst_n = 1'b1;
    chk("rst_set", 32'(set), 1);
    chk("rst_btn_add", 32'(btn_add), 0);
    chk("rst_btn_sub", 32'(btn_sub), 0);
    a0 = n_add; s0 = n_sub;
    nclk(50);
    chk("idle_set", 32'(set), 1);
    chk("idle_pulses", (n_add - a0) + (n_sub - s0), 0);

    key_add = 1'b0;
    nclk(20);
    key_add = 1'b1;
    rel_edge = cyc + 1;
    a0 = n_add; s0 = n_sub;
    nclk(20);
    chk("add_pulse_count", n_add - a0, 1);
    chk("add_pulse_latency", last_add - rel_edge, 10);
    chk("add_sub_quiet", n_sub - s0, 0);

    a0 = n_add;
    repeat (4) begin
      key_add = 1'b0; nclk(5);
      key_add = 1'b1; nclk(5);
    end
    chk("glitch_pulses", n_add - a0, 0);
    nclk(30);
    chk("glitch_after", 32'((n_add - a0) <= 1), 1);

    for (int i = 0; i < 3; i++) begin
      key_mode = 1'b0; nclk(20);
      key_mode = 1'b1; nclk(20);
      chk("mode_step_dut", 32'(set), 32'(steps[i]));
      chk("mode_step_model", 32'(exp_set), 32'(steps[i]));
    end

    key_mode = 1'b0; nclk(20);
    key_mode = 1'b1;
    wait_set(3'b010, 40, "enter_min", t0);
    wait_set(3'b001, IDLE + 20, "timeout_min", t1);
    chk("timeout_len", t1 - t0, IDLE);

    @(negedge clk);
    key_mode = 1'b0; nclk(20);
    key_mode = 1'b1;
    wait_set(3'b010, 40, "reenter_min", t0);
    repeat (59) @(posedge clk);
    @(negedge clk);
    key_add = 1'b0;
    wait_set(3'b001, 250, "timeout_restart", t1);
    chk("timeout_restart_len", t1 - t0, 170);
    @(negedge clk);
    key_add = 1'b1;
    nclk(20);

    key_add = 1'b0; key_sub = 1'b0; nclk(20);
    a0 = n_add; s0 = n_sub;
    key_add = 1'b1; key_sub = 1'b1; nclk(20);
    chk("both_rel_add", n_add - a0, 0);
    chk("both_rel_sub", n_sub - s0, 0);

    key_mode = 1'b0; key_add = 1'b0; nclk(20);
    a0 = n_add;
    key_mode = 1'b1; key_add = 1'b1; nclk(20);
    chk("mode_add_set", 32'(set), 32'(3'b010));
    chk("mode_add_quiet", n_add - a0, 0);

    key_add = 1'b0; nclk(20);
    key_add = 1'b1;
    a0 = n_add;
    nclk(4);
    rst_n = 1'b0;
    #1;
    chk("rst_async_set", 32'(set), 1);
    chk("rst_async_btn", 32'(btn_add), 0);
    nclk(3);
    rst_n = 1'b1;
    nclk(30);
    chk("rst_mid_debounce", n_add - a0, 0);

    key_add = 1'b0;
    rst_n = 1'b0;
    nclk(3);
    rst_n = 1'b1;
    a0 = n_add;
    nclk(20);
    chk("held_press_quiet", n_add - a0, 0);
    key_add = 1'b1;
    nclk(20);
    chk("held_release_pulse", n_add - a0, 1);

    run_random(3000, 24);
    run_random(3000, 160);
    {key_sub, key_add, key_mode} = 3'b111;
    rst_n = 1'b1;
    nclk(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
